// File: rtl/lost_pkg.sv
// -----------------------------------------------------------------------------
// lost_pkg
//   Shared definitions for the LOST transition-capture buffer.
//   - rd_state_e : drain-side FSM states (IDLE, FETCH, LOAD, SEND).
//   - DEF_WIDTH / DEF_DEPTH : default record width and RAM address bits.
//   - BYTES      : bytes per record at the default width.
//   - rec_bytes  : bytes per record for an arbitrary width.
//   - ptr_diff   : wrap-aware pointer difference used by writer and reader
//                  for count / full / empty.
// -----------------------------------------------------------------------------
package lost_pkg;

  localparam int unsigned DEF_WIDTH = 64;
  localparam int unsigned DEF_DEPTH = 6;
  localparam int unsigned BYTES     = DEF_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    SEND  = 2'd3
  } rd_state_e;

  function automatic int unsigned rec_bytes(input int unsigned width);
    return width / 8;
  endfunction

  // Pointers carry one extra wrap bit above the RAM address, so the plain
  // difference modulo 2**ptr_bits distinguishes full (2**(ptr_bits-1)) from
  // empty (0). Callers truncate the result to their pointer width.
  function automatic logic [31:0] ptr_diff(input logic [31:0] wr,
                                           input logic [31:0] rd,
                                           input int unsigned ptr_bits);
    logic [31:0] mask;
    mask = (ptr_bits >= 32) ? '1 : ((32'd1 << ptr_bits) - 32'd1);
    return (wr - rd) & mask;
  endfunction

endpackage

// File: rtl/record_serializer.sv
// -----------------------------------------------------------------------------
// record_serializer
//   Loads one WIDTH-bit record and presents it as bytes, MSB byte first, on a
//   valid/ready stream. byte_data/byte_valid are registered and held while the
//   sink stalls. last_accept strobes (combinationally) in the cycle whose
//   clock edge accepts the final byte.
//
//   clk         in   clock
//   reset       in   synchronous, active-high
//   load        in   capture load_data and start presenting byte 0
//   load_data   in   WIDTH-bit record
//   byte_ready  in   sink ready
//   byte_data   out  current byte
//   byte_valid  out  byte_data valid
//   last_accept out  final byte is being accepted at this edge
// -----------------------------------------------------------------------------
module record_serializer
  import lost_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             byte_ready,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  output logic             last_accept
);

  localparam int unsigned NBYTES = rec_bytes(WIDTH);
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  // shift_q holds the bytes not yet presented, left-aligned.
  logic [WIDTH-1:0] shift_q,      shift_d;
  logic [7:0]       byte_data_q,  byte_data_d;
  logic             byte_valid_q, byte_valid_d;
  logic [IDX_W-1:0] idx_q,        idx_d;

  logic accept;

  assign accept      = byte_valid_q && byte_ready;
  assign last_accept = accept && (idx_q == LAST_IDX);

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path leaves one
    // unassigned and no latch is inferred.
    shift_d      = shift_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = byte_valid_q;
    idx_d        = idx_q;

    if (load) begin
      byte_data_d  = load_data[WIDTH-1 -: 8];
      shift_d      = load_data << 8;
      byte_valid_d = 1'b1;
      idx_d        = '0;
    end else if (accept) begin
      if (idx_q == LAST_IDX) begin
        // Final byte gone: drop valid, leave byte_data as last presented.
        byte_valid_d = 1'b0;
        idx_d        = '0;
      end else begin
        byte_data_d = shift_q[WIDTH-1 -: 8];
        shift_d     = shift_q << 8;
        idx_d       = idx_q + IDX_W'(1);
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the data registers are reset too, so byte_data reads 0 out of
      // reset and a partial record cannot leak after a mid-record reset.
      shift_q      <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      idx_q        <= '0;
    end else begin
      shift_q      <= shift_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      idx_q        <= idx_d;
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;

endmodule

// File: rtl/logbuf_reader.sv
// -----------------------------------------------------------------------------
// logbuf_reader
//   Drain side of the LOST capture buffer. Follows the writer's pointer around
//   the circular RAM, reads each completed record through port B (one-cycle
//   registered read) and streams it out MSB byte first. Owns rd_ptr, which the
//   writer uses for full detection.
//
//   clk        in   clock (writer, RAM port B and host link share it)
//   reset      in   synchronous, active-high
//   enable     in   permits starting a new record
//   wr_ptr     in   writer next-write pointer, MSB = wrap bit
//   rd_ptr     out  next record to read, MSB = wrap bit
//   count      out  wr_ptr - rd_ptr modulo 2**(DEPTH+1)
//   empty      out  count == 0
//   ram_addr   out  port B address (= rd_ptr[DEPTH-1:0])
//   ram_dout   in   port B registered read data
//   byte_data  out  current byte
//   byte_valid out  byte_data valid
//   byte_ready in   sink ready
//   rec_done   out  one-cycle pulse after a record's last byte is accepted
// -----------------------------------------------------------------------------
module logbuf_reader
  import lost_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DEPTH:0]   wr_ptr,
  output logic [DEPTH:0]   rd_ptr,
  output logic [DEPTH:0]   count,
  output logic             empty,
  output logic [DEPTH-1:0] ram_addr,
  input  logic [WIDTH-1:0] ram_dout,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             rec_done
);

  rd_state_e      state_q,    state_d;
  logic [DEPTH:0] rd_ptr_q,   rd_ptr_d;
  logic           rec_done_q, rec_done_d;

  logic load;
  logic last_accept;

  assign count    = (DEPTH + 1)'(ptr_diff(32'(wr_ptr), 32'(rd_ptr_q), DEPTH + 1));
  assign empty    = (count == '0);
  // The address only moves when rd_ptr moves (on return to IDLE), so it is
  // stable through FETCH and LOAD and the RAM output in LOAD is this record.
  assign ram_addr = rd_ptr_q[DEPTH-1:0];
  assign load     = (state_q == LOAD);

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    rec_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable && !empty) state_d = FETCH;
      end
      FETCH: begin
        // RAM registers ram_dout at the edge leaving FETCH.
        state_d = LOAD;
      end
      LOAD: begin
        state_d = SEND;
      end
      SEND: begin
        // enable and wr_ptr are ignored here; the record always completes.
        if (last_accept) begin
          rd_ptr_d   = rd_ptr_q + (DEPTH + 1)'(1);
          rec_done_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      rec_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      rec_done_q <= rec_done_d;
    end
  end

  record_serializer #(
    .WIDTH (WIDTH)
  ) u_serializer (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_data   (ram_dout),
    .byte_ready  (byte_ready),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .last_accept (last_accept)
  );

  assign rd_ptr   = rd_ptr_q;
  assign rec_done = rec_done_q;

endmodule

// File: tb/tb_logbuf_reader.sv
// -----------------------------------------------------------------------------
// tb_logbuf_reader
//   Directed bench for logbuf_reader at WIDTH=64, DEPTH=2 (4-record buffer).
//   A behavioural RAM with one-cycle registered read stands in for port B.
//   Inputs are driven and outputs sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_logbuf_reader;

  localparam int W  = 64;
  localparam int D  = 2;
  localparam int NB = W / 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic [D:0]     wr_ptr;
  logic [D:0]     rd_ptr;
  logic [D:0]     count;
  logic           empty;
  logic [D-1:0]   ram_addr;
  logic [W-1:0]   ram_dout;
  logic [7:0]     byte_data;
  logic           byte_valid;
  logic           byte_ready;
  logic           rec_done;

  logic [W-1:0]   mem [4];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) ram_dout <= mem[ram_addr];

  logbuf_reader #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr),
    .count      (count),
    .empty      (empty),
    .ram_addr   (ram_addr),
    .ram_dout   (ram_dout),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .rec_done   (rec_done)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable     = 1'b0;
    wr_ptr     = '0;
    byte_ready = 1'b0;
    reset      = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Receives one record starting from the current sample point. stall selects
  // the 1,0,0,1 ready pattern; en_drop_k drops enable while byte k is shown;
  // abort_k stops after k bytes have been accepted (NB = full record).
  // steps returns the clock edges consumed.
  task automatic recv(input logic [W-1:0] rec, input bit stall,
                      input int en_drop_k, input int abort_k,
                      input string tag, output int steps);
    int         k;
    int         vc;
    bit         prev_stall;
    logic [7:0] prev_data;
    logic [7:0] exp_byte;
    k = 0; vc = 0; prev_stall = 1'b0; prev_data = '0; steps = 0;
    for (int c = 0; c < 200; c++) begin
      if (prev_stall) begin
        vectors++;
        if (byte_valid !== 1'b1 || byte_data !== prev_data) begin
          miscompares++;
          $display("FAIL %s hold: valid=%b data=%h, required valid=1 data=%h",
                   tag, byte_valid, byte_data, prev_data);
        end
      end
      if (byte_valid === 1'b1) begin
        vectors++;
        if (rec_done !== 1'b0) begin
          miscompares++;
          $display("FAIL %s early_rec_done: got %b, required 0", tag, rec_done);
        end
        if (k == en_drop_k) enable = 1'b0;
        byte_ready = stall ? ((vc % 4 == 0) || (vc % 4 == 3)) : 1'b1;
        vc++;
        prev_stall = !byte_ready;
        prev_data  = byte_data;
        if (byte_ready) begin
          exp_byte = rec[W-1-8*k -: 8];
          vectors++;
          if (byte_data !== exp_byte) begin
            miscompares++;
            $display("FAIL %s byte%0d: got %h, required %h", tag, k, byte_data, exp_byte);
          end
          k++;
        end
      end else begin
        prev_stall = 1'b0;
        byte_ready = 1'b1;
      end
      if (k == abort_k) break;
      step();
      steps++;
    end
    vectors++;
    if (k != abort_k) begin
      miscompares++;
      $display("FAIL %s timeout: accepted %0d bytes, required %0d", tag, k, abort_k);
      return;
    end
    step();
    steps++;
    if (abort_k == NB) begin
      vectors++;
      if (rec_done !== 1'b1 || byte_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s end: rec_done=%b valid=%b, required rec_done=1 valid=0",
                 tag, rec_done, byte_valid);
      end
    end else begin
      exp_byte = rec[W-1-8*k -: 8];
      vectors++;
      if (byte_valid !== 1'b1 || byte_data !== exp_byte) begin
        miscompares++;
        $display("FAIL %s next_byte: valid=%b data=%h, required valid=1 data=%h",
                 tag, byte_valid, byte_data, exp_byte);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (byte_valid !== 1'b0 || byte_data !== 8'h00 || rec_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b data=%h rec_done=%b, required 0/00/0",
               byte_valid, byte_data, rec_done);
    end
    vectors++;
    if (rd_ptr !== 3'd0 || count !== 3'd0 || empty !== 1'b1 || ram_addr !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_ptrs: rd_ptr=%0d count=%0d empty=%b addr=%0d, required 0/0/1/0",
               rd_ptr, count, empty, ram_addr);
    end
  endtask

  task automatic test_basic();
    int steps;
    do_reset();
    mem[0]     = 64'h0123_4567_89AB_CDEF;
    enable     = 1'b1;
    byte_ready = 1'b1;
    wr_ptr     = 3'd1;
    #1;
    vectors++;
    if (count !== 3'd1 || empty !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_count: count=%0d empty=%b, required 1/0", count, empty);
    end
    step();
    step();
    vectors++;
    if (byte_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_latency_early: valid=%b, required 0", byte_valid);
    end
    step();
    vectors++;
    if (byte_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_latency: valid=%b, required 1", byte_valid);
    end
    recv(64'h0123_4567_89AB_CDEF, 1'b0, -1, NB, "basic", steps);
    vectors++;
    if (steps !== 8 || rd_ptr !== 3'd1 || empty !== 1'b1 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL basic_after: steps=%0d rd_ptr=%0d empty=%b count=%0d, required 8/1/1/0",
               steps, rd_ptr, empty, count);
    end
    step();
    vectors++;
    if (rec_done !== 1'b0 || byte_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_pulse: rec_done=%b valid=%b, required 0/0", rec_done, byte_valid);
    end
  endtask

  task automatic test_backpressure();
    int steps;
    mem[1] = 64'hFEDC_BA98_7654_3210;
    wr_ptr = 3'd2;
    recv(64'hFEDC_BA98_7654_3210, 1'b1, -1, NB, "stall", steps);
    vectors++;
    if (rd_ptr !== 3'd2 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_after: rd_ptr=%0d empty=%b, required 2/1", rd_ptr, empty);
    end
  endtask

  task automatic test_wrap();
    int steps;
    mem[2] = 64'h1122_3344_5566_7788;
    wr_ptr = 3'd3;
    recv(64'h1122_3344_5566_7788, 1'b0, -1, NB, "wrap_pre", steps);
    vectors++;
    if (rd_ptr !== 3'd3 || ram_addr !== 2'd3 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_pre: rd_ptr=%0d addr=%0d empty=%b, required 3/3/1",
               rd_ptr, ram_addr, empty);
    end
    mem[3] = 64'hA0A1_A2A3_A4A5_A6A7;
    mem[0] = 64'hB0B1_B2B3_B4B5_B6B7;
    wr_ptr = 3'd5;
    #1;
    vectors++;
    if (count !== 3'd2) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d, required 2", count);
    end
    recv(64'hA0A1_A2A3_A4A5_A6A7, 1'b0, -1, NB, "wrap_a", steps);
    vectors++;
    if (steps !== 11 || rd_ptr !== 3'b100 || count !== 3'd1 || ram_addr !== 2'd0) begin
      miscompares++;
      $display("FAIL wrap_mid: steps=%0d rd_ptr=%0d count=%0d addr=%0d, required 11/4/1/0",
               steps, rd_ptr, count, ram_addr);
    end
    recv(64'hB0B1_B2B3_B4B5_B6B7, 1'b0, -1, NB, "wrap_b", steps);
    vectors++;
    if (steps !== 11 || rd_ptr !== 3'd5 || count !== 3'd0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_end: steps=%0d rd_ptr=%0d count=%0d empty=%b, required 11/5/0/1",
               steps, rd_ptr, count, empty);
    end
  endtask

  task automatic test_full();
    int         steps;
    logic [W-1:0] recs [4];
    recs[0] = 64'h1000_0000_0000_0001;
    recs[1] = 64'h2000_0000_0000_0002;
    recs[2] = 64'h3000_0000_0000_0003;
    recs[3] = 64'h4000_0000_0000_0004;
    do_reset();
    for (int i = 0; i < 4; i++) mem[i] = recs[i];
    wr_ptr = 3'd4;
    #1;
    vectors++;
    if (count !== 3'd4 || empty !== 1'b0) begin
      miscompares++;
      $display("FAIL full_count: count=%0d empty=%b, required 4/0", count, empty);
    end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      recv(recs[i], 1'b0, -1, NB, "full", steps);
      vectors++;
      if (steps !== 11) begin
        miscompares++;
        $display("FAIL full_cycles%0d: got %0d, required 11", i, steps);
      end
    end
    vectors++;
    if (rd_ptr !== 3'b100 || count !== 3'd0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL full_end: rd_ptr=%0d count=%0d empty=%b, required 4/0/1",
               rd_ptr, count, empty);
    end
  endtask

  task automatic test_enable();
    int steps;
    do_reset();
    mem[0] = 64'hC0C1_C2C3_C4C5_C6C7;
    mem[1] = 64'hD0D1_D2D3_D4D5_D6D7;
    wr_ptr = 3'd2;
    enable = 1'b1;
    recv(64'hC0C1_C2C3_C4C5_C6C7, 1'b0, 3, NB, "en_first", steps);
    vectors++;
    if (steps !== 11 || rd_ptr !== 3'd1) begin
      miscompares++;
      $display("FAIL en_first: steps=%0d rd_ptr=%0d, required 11/1", steps, rd_ptr);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (byte_valid !== 1'b0 || rd_ptr !== 3'd1) begin
        miscompares++;
        $display("FAIL en_hold%0d: valid=%b rd_ptr=%0d, required 0/1", i, byte_valid, rd_ptr);
      end
    end
    enable = 1'b1;
    recv(64'hD0D1_D2D3_D4D5_D6D7, 1'b0, -1, NB, "en_second", steps);
    vectors++;
    if (steps !== 11 || rd_ptr !== 3'd2) begin
      miscompares++;
      $display("FAIL en_second: steps=%0d rd_ptr=%0d, required 11/2", steps, rd_ptr);
    end
  endtask

  task automatic test_reset_mid();
    int steps;
    do_reset();
    mem[0] = 64'hE0E1_E2E3_E4E5_E6E7;
    wr_ptr = 3'd1;
    enable = 1'b1;
    recv(64'hE0E1_E2E3_E4E5_E6E7, 1'b0, -1, 4, "rst_part", steps);
    reset = 1'b1;
    step();
    vectors++;
    if (byte_valid !== 1'b0 || rd_ptr !== 3'd0 || byte_data !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_mid: valid=%b rd_ptr=%0d data=%h, required 0/0/00",
               byte_valid, rd_ptr, byte_data);
    end
    reset = 1'b0;
    recv(64'hE0E1_E2E3_E4E5_E6E7, 1'b0, -1, NB, "rst_resend", steps);
    vectors++;
    if (steps !== 11 || rd_ptr !== 3'd1) begin
      miscompares++;
      $display("FAIL rst_resend: steps=%0d rd_ptr=%0d, required 11/1", steps, rd_ptr);
    end
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    wr_ptr     = '0;
    byte_ready = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_full();
    test_enable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/logbuf_reader.md
# logbuf_reader

Drain side of the LOST transition-capture buffer. Reads completed records from port B of the capture dual-port RAM and follows the capture writer's pointer around the circular buffer. Serializes each WIDTH-bit record into bytes, MSB byte first, over a valid/ready stream toward the host link. It owns the read pointer that the writer uses for full detection.

## Interface

Parameters:

- WIDTH, 64, record width in bits; must be a multiple of 8, minimum 8.
- DEPTH, 6, RAM address bits; the buffer holds 2**DEPTH records.

Ports:

- clk  in  1  single clock; capture writer, RAM port B and host link all run on it.
- reset  in  1  synchronous, active-high.
- enable  in  1  permits starting a new record; does not abort a record in progress.
- wr_ptr  in  DEPTH+1  writer's next-write pointer; MSB is the wrap bit.
- rd_ptr  out  DEPTH+1  next record to read; MSB is the wrap bit.
- count  out  DEPTH+1  wr_ptr − rd_ptr, modulo 2**(DEPTH+1); range 0..2**DEPTH.
- empty  out  1  count == 0.
- ram_addr  out  DEPTH  port B address, equal to rd_ptr[DEPTH-1:0] at all times.
- ram_dout  in  WIDTH  port B registered read data; one-cycle read latency.
- byte_data  out  8  current byte.
- byte_valid  out  1  byte_data is valid.
- byte_ready  in  1  sink accepts the byte when byte_valid and byte_ready are both high at a clk edge.
- rec_done  out  1  one-cycle pulse after the last byte of a record is accepted.

Port B write enable is tied low at the RAM instance. This block never writes.

## Operation

- States:
  - IDLE: if enable and !empty, go to FETCH.
  - FETCH: wait one cycle for the RAM to register ram_dout; go to LOAD.
  - LOAD: capture ram_dout into the shift register, set byte index to 0; go to SEND.
  - SEND: byte_valid=1.
- Handshake in SEND:
  - Each accepted byte advances the index.
  - Acceptance of byte WIDTH/8−1 increments rd_ptr, pulses rec_done and returns to IDLE.
- Byte order: byte k = record[WIDTH−1−8k -: 8].
- byte_data and byte_valid are held stable while byte_valid && !byte_ready. byte_valid never drops without acceptance, except on reset.
- Pointer arithmetic is DEPTH+1 bits with natural wrap. Index 2**DEPTH−1 wraps to 0 and the wrap bit toggles.
- Full (count == 2**DEPTH) is legal. The reader behaves normally; preventing overwrite of unread records is the writer's job.
- Writer contract: wr_ptr increments no earlier than the cycle after the RAM write edge. Addresses read are therefore always written in an earlier cycle, and no same-address read/write collision occurs.
- enable falling mid-record: the current record completes. No new FETCH starts while enable is low.
- wr_ptr advancing during SEND: no effect until the return to IDLE. Back-to-back records go IDLE→FETCH with no extra gaps.
- Reset at any time: partial record discarded, nothing replayed. State returns to IDLE.

## Timing

- Reset values: state=IDLE, rd_ptr=0, byte_valid=0, byte_data=0, rec_done=0, byte index=0. count and empty follow the combinational relation to wr_ptr.
- Latency: IDLE cycle with the start condition true → byte_valid high 3 cycles later (FETCH, LOAD, then SEND).
- Back-to-back throughput: with byte_ready held high, one record takes WIDTH/8 + 3 cycles (8 bytes + 3 overhead = 11 cycles at WIDTH=64).
- rd_ptr, count and empty update in the same cycle that rec_done is high.
- ram_addr changes only when rd_ptr changes, i.e. only on IDLE entry. It is stable through FETCH and LOAD.
- All outputs are registered except ram_addr, count and empty, which are combinational from registers and wr_ptr.

## Structure

- Shared package lost_pkg holds:
  - the state enum (IDLE, FETCH, LOAD, SEND);
  - localparam BYTES = WIDTH/8;
  - the pointer-difference helper used by both writer and reader for count/full.
- One natural sub-module, record_serializer: WIDTH-bit load register, byte index counter, valid/ready output stage and a last-byte strobe. The FSM and pointers stay in logbuf_reader.

## Test plan

- Reset, then wr_ptr=1 with RAM[0]=64'h0123_4567_89AB_CDEF and byte_ready=1 → bytes 01,23,45,67,89,AB,CD,EF; first byte_valid 3 cycles after IDLE sees non-empty; rec_done once; rd_ptr=1, empty=1.
- Backpressure: byte_ready toggles 1,0,0,1,… during a record → byte_data and byte_valid held while stalled; byte sequence unchanged; no byte duplicated or skipped.
- Wrap, DEPTH=2: preload rd_ptr=wr_ptr=3, then write 2 records so wr_ptr=5 → reads RAM[3] then RAM[0]; rd_ptr goes 3→4→5; wrap bit set; count=0 at end.
- Full: wr_ptr=2**DEPTH with rd_ptr=0 → count=2**DEPTH, empty=0; all 2**DEPTH records drain in order, 11 cycles each with byte_ready=1.
- enable deasserted during byte 3 of a record with 2 records pending → first record completes, second not started until enable returns, then starts 3 cycles later.
- Reset asserted in SEND after byte 4 accepted → next cycle byte_valid=0 and rd_ptr=0; after release, the record at address 0 is resent from byte 0.
